mem_lsu: RTL

Load/store unit sitting directly upstream of the word-only data memory (mem_data).
- Accepts byte/half/word load and store requests from the execute stage.
- Checks alignment and the data-region range, and converts each request into word-granular mem_rd_en/mem_wr_en cycles. Sub-word stores use read-modify-write.
- Returns sign- or zero-extended load data with a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/mem_lsu.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states
// and data-region bounds helpers.
package lsu_pkg;

  localparam logic [1:0] LSU_SZ_B = 2'd0;
  localparam logic [1:0] LSU_SZ_H = 2'd1;
  localparam logic [1:0] LSU_SZ_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_ISSUE,
    S_LD_WAIT,
    S_ST_RD,
    S_ST_MERGE,
    S_ST_WR,
    S_RESP
  } lsu_state_t;

  // Data region occupies the upper half of the memory, in word indices [lo, hi).
  function automatic int unsigned lsu_region_lo(input int unsigned depth);
    return depth / 2;
  endfunction

  function automatic int unsigned lsu_region_hi(input int unsigned depth);
    return depth;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extract+extend a byte/half from a word for loads,
// and merge a byte/half into a word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;

  // lane_i is already force-aligned for halves, so one byte-granular shift serves both
  assign shamt   = {lane_i, 3'b000};
  assign shifted = word_i >> shamt;

  always_comb begin
    ld_data_o = word_i;
    st_data_o = wdata_i;
    mask      = 32'h0;
    case (size_i)
      LSU_SZ_B: begin
        ld_data_o = unsigned_i ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        mask      = 32'h0000_00FF << shamt;
        st_data_o = (word_i & ~mask) | ((wdata_i << shamt) & mask);
      end
      LSU_SZ_H: begin
        ld_data_o = unsigned_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        mask      = 32'h0000_FFFF << shamt;
        st_data_o = (word_i & ~mask) | ((wdata_i << shamt) & mask);
      end
      default: begin
        ld_data_o = word_i;
        st_data_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of the word-only data memory; sub-word stores use RMW.
// LSU_ALIGN_CHECK_EN: defined -> misaligned half/word error out; undefined -> force-aligned.
//
// state      | meaning
// S_IDLE     | ready for a request
// S_LD_ISSUE | memory read strobe for a load
// S_LD_WAIT  | read data returns; extract lane and extend
// S_ST_RD    | memory read strobe for a sub-word store
// S_ST_MERGE | read data returns; merge store lane, register result
// S_ST_WR    | memory write strobe
// S_RESP     | one-cycle response pulse
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int WIW = ADDR_WIDTH - 2;
  localparam logic [WIW-1:0] WORD_LO = WIW'(lsu_region_lo(MEM_DEPTH));
  localparam logic [WIW-1:0] WORD_HI = WIW'(lsu_region_hi(MEM_DEPTH));

  lsu_state_t state_q, state_d;

  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q, lane_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, din_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [WIW-1:0]  word_idx;
  logic            accept, range_err, size_err, mis_err, acc_err;
  logic [1:0]      lane_d;
  logic [31:0]     ld_data, st_data;

  assign accept    = req_valid && (state_q == S_IDLE);
  assign word_idx  = req_addr[ADDR_WIDTH-1:2];
  assign range_err = (word_idx < WORD_LO) || (word_idx >= WORD_HI);
  assign size_err  = (req_size == 2'd3);
`ifdef LSU_ALIGN_CHECK_EN
  assign mis_err   = ((req_size == LSU_SZ_H) && req_addr[0]) ||
                     ((req_size == LSU_SZ_W) && (req_addr[1:0] != 2'b00));
`else
  assign mis_err   = 1'b0;
`endif
  assign acc_err   = range_err || size_err || mis_err;

  always_comb begin
    lane_d = req_addr[1:0];
    if (req_size == LSU_SZ_H)      lane_d[0] = 1'b0;
    else if (req_size == LSU_SZ_W) lane_d    = 2'b00;
  end

  lsu_lane_align u_lane (
    .size_i     (size_q),
    .lane_i     (lane_q),
    .unsigned_i (uns_q),
    .word_i     (mem_dout),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .st_data_o  (st_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        if (acc_err)                    state_d = S_RESP;
        else if (!req_we)               state_d = S_LD_ISSUE;
        else if (req_size == LSU_SZ_W)  state_d = S_ST_WR;
        else                            state_d = S_ST_RD;
      end
      S_LD_ISSUE: state_d = S_LD_WAIT;
      S_LD_WAIT:  state_d = S_RESP;
      S_ST_RD:    state_d = S_ST_MERGE;
      S_ST_MERGE: state_d = S_ST_WR;
      S_ST_WR:    state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    mem_rd_en = (state_q == S_LD_ISSUE) || (state_q == S_ST_RD);
    mem_wr_en = (state_q == S_ST_WR);
    rsp_valid = (state_q == S_RESP);
    rsp_err   = (state_q == S_RESP) && err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      lane_q  <= 2'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      din_q   <= '0;
      addr_q  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= acc_err;
        size_q  <= req_size;
        lane_q  <= lane_d;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        if (!acc_err) begin
          addr_q <= {word_idx, 2'b00};
          if (req_we && (req_size == LSU_SZ_W)) din_q <= req_wdata;
        end
      end
      if (state_q == S_LD_WAIT)  rdata_q <= ld_data;
      if (state_q == S_ST_MERGE) din_q   <= st_data;
    end
  end

  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;

endmodule
